updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
//
// PURPOSE
// Parametrised up/down counter; the next generation of the 32-bit loadable counter.
// Adds: configurable width, programmable upper limit (count range 0..limit),
// selectable wrap/saturate, enable, terminal-count pulse, sticky over/underflow flags.
// Sits in the counter subsystem; driven by the stimulus interface, checked by the scoreboard.
//
// PARAMETERS
// WIDTH    32  counter, data and limit width in bits (>=2)
// RST_VAL  0   data_out value after reset (must be <= limit in use)
//
// PORTS
// clk        in   1      single clock; all state updates on posedge
// rst        in   1      synchronous reset, active-low (rst==0 at posedge resets)
// en         in   1      count enable; one step per cycle while high
// load       in   1      load data into counter
// mode       in   1      1 = count up, 0 = count down
// sat        in   1      1 = saturate at bounds, 0 = wrap
// data       in   WIDTH  load value
// limit      in   WIDTH  upper bound of count range (inclusive), sampled every cycle
// clr_flags  in   1      clears ovf/unf
// data_out   out  WIDTH  current count (registered)
// tc         out  1      terminal-count pulse, one cycle
// ovf        out  1      sticky overflow flag
// unf        out  1      sticky underflow flag
//
// BEHAVIOUR
// - Reset (rst==0 at posedge): data_out=RST_VAL, tc=0, ovf=0, unf=0. Overrides all inputs.
// - Priority per cycle: rst > load > en. No input: hold, tc=0.
// - load: data_out<=data if data<=limit; else data_out<=limit, ovf<=1. tc=0. en ignored.
// - en, mode=1, data_out<limit: data_out+1. At data_out==limit (boundary):
//   wrap -> 0; sat -> hold limit. Both: ovf<=1, tc<=1.
// - en, mode=0, data_out>0: data_out-1. At data_out==0 (boundary):
//   wrap -> limit; sat -> hold 0. Both: unf<=1, tc<=1.
// - Out of range (en, data_out>limit, e.g. limit lowered): data_out<=limit,
//   ovf<=1, tc<=1, for either mode and sat setting.
// - limit==0: counter pinned at 0; every enabled step is a boundary event.
// - tc registered: high exactly the cycle after the boundary step (same edge as data_out update);
//   consecutive boundary steps in sat mode give tc high every cycle.
// - clr_flags clears ovf/unf next edge; same-cycle new event wins (flag stays/sets 1).
// - All arithmetic mod 2^WIDTH on WIDTH-bit unsigned values; no carry out.
// - Reset mid-count: count discarded, RST_VAL restored next edge; pending tc suppressed.
// - Latency: every output changes only on clk posedge, 1 cycle after inputs sampled.
//
// TESTING
// 1 Reset: rst=0 two cycles, en=1,load=1 -> data_out=0, tc=0, ovf=0, unf=0.
// 2 Wrap up: WIDTH=8, limit=5, load 3, mode=1, sat=0, en 4 cycles -> 4,5,0,1; tc high on
//   the edge giving 0; ovf=1 thereafter.
// 3 Saturate down: limit=10, load 2, mode=0, sat=1, en 4 cycles -> 1,0,0,0; tc high on
//   last two edges; unf=1; clr_flags with en=0 -> unf=0 next cycle.
// 4 Load over limit: limit=100, load data=200 -> data_out=100, ovf=1, tc=0.
// 5 Limit lowered: data_out=50, limit changed to 20, en=1 mode=0 -> data_out=20, ovf=1, tc=1.
// 6 Full-width wrap: WIDTH=32, limit=32'hFFFF_FFFF, load 32'hFFFF_FFFE, up, sat=0, en
//   2 cycles -> FFFF_FFFF then 0, tc=1; load+en same cycle -> load wins.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter over 0..limit with wrap/saturate, terminal-count pulse and sticky flags.
// Latency: all outputs are registered and update one clk edge after their inputs are sampled.
// Backpressure: none; one load or one count step is accepted every cycle.
module updown_counter_param #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q,  tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic at_top;
    logic at_bottom;
    logic out_of_range;

    assign at_top       = (cnt_q == limit);
    assign at_bottom    = (cnt_q == '0);
    assign out_of_range = (cnt_q > limit);

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        // A new event this cycle overrides a simultaneous clear.
        ovf_d = ovf_q & ~clr_flags;
        unf_d = unf_q & ~clr_flags;

        if (load) begin
            if (data <= limit) begin
                cnt_d = data;
            end else begin
                cnt_d = limit;
                ovf_d = 1'b1;
            end
        end else if (en) begin
            if (out_of_range) begin
                cnt_d = limit;
                ovf_d = 1'b1;
                tc_d  = 1'b1;
            end else if (mode) begin
                if (at_top) begin
                    cnt_d = sat ? limit : '0;
                    ovf_d = 1'b1;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (at_bottom) begin
                    cnt_d = sat ? '0 : limit;
                    unf_d = 1'b1;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= RST_CNT;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign data_out = cnt_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed and randomized bench for updown_counter_param against a modular-arithmetic reference model.
module tb_updown_counter_param;

    localparam int W = 32;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst, en, load, mode, sat, clr_flags;
    logic [W-1:0] data, limit;
    logic [W-1:0] data_out;
    logic         tc, ovf, unf;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: count is a plain integer in the range 0..limit.
    longint m_cnt = 0;
    bit     m_tc  = 0;
    bit     m_ovf = 0;
    bit     m_unf = 0;

    updown_counter_param #(.WIDTH(W), .RST_VAL(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .mode      (mode),
        .sat       (sat),
        .data      (data),
        .limit     (limit),
        .clr_flags (clr_flags),
        .data_out  (data_out),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The counter range is the ring 0..lim, so wrapping is arithmetic modulo lim+1.
    task automatic model_step();
        longint lim, d;
        lim = longint'(limit);
        d   = longint'(data);
        if (!rst) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        m_tc = 0;
        if (clr_flags) begin
            m_ovf = 0; m_unf = 0;
        end
        if (load) begin
            m_cnt = (d > lim) ? lim : d;
            if (d > lim) m_ovf = 1;
        end else if (en) begin
            if (m_cnt > lim) begin
                m_cnt = lim; m_ovf = 1; m_tc = 1;
            end else if (mode) begin
                if (m_cnt == lim) begin m_ovf = 1; m_tc = 1; end
                m_cnt = sat ? ((m_cnt + 1 > lim) ? lim : m_cnt + 1) : (m_cnt + 1) % (lim + 1);
            end else begin
                if (m_cnt == 0) begin m_unf = 1; m_tc = 1; end
                m_cnt = sat ? ((m_cnt == 0) ? 0 : m_cnt - 1) : (m_cnt + lim) % (lim + 1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("data_out", 64'(data_out), 64'(m_cnt));
        chk("tc",       64'(tc),       64'(m_tc));
        chk("ovf",      64'(ovf),      64'(m_ovf));
        chk("unf",      64'(unf),      64'(m_unf));
    endtask

    task automatic idle();
        en = 0; load = 0; clr_flags = 0;
    endtask

    initial begin
        longint lim_r;
        rst = 0; en = 1; load = 1; mode = 1; sat = 0; clr_flags = 0;
        data = 32'd7; limit = 32'd5;

        // Reset overrides load and en.
        tick(); tick();
        chk("rst_cnt", 64'(data_out), 64'd0);
        chk("rst_tc",  64'(tc),       64'd0);
        chk("rst_ovf", 64'(ovf),      64'd0);
        chk("rst_unf", 64'(unf),      64'd0);

        // Wrap up with limit 5.
        rst = 1; idle(); load = 1; data = 32'd3; limit = 32'd5;
        tick();
        idle(); en = 1; mode = 1; sat = 0;
        tick(); chk("wrap_1", 64'(data_out), 64'd4);
        tick(); chk("wrap_2", 64'(data_out), 64'd5); chk("wrap_2_tc", 64'(tc), 64'd0);
        tick(); chk("wrap_3", 64'(data_out), 64'd0); chk("wrap_3_tc", 64'(tc), 64'd1);
        tick(); chk("wrap_4", 64'(data_out), 64'd1); chk("wrap_4_tc", 64'(tc), 64'd0);
        chk("wrap_ovf", 64'(ovf), 64'd1);

        // Saturate down with limit 10, then clear flags.
        idle(); load = 1; data = 32'd2; limit = 32'd10;
        tick();
        idle(); en = 1; mode = 0; sat = 1;
        tick(); chk("sat_1", 64'(data_out), 64'd1);
        tick(); chk("sat_2", 64'(data_out), 64'd0); chk("sat_2_tc", 64'(tc), 64'd0);
        tick(); chk("sat_3", 64'(data_out), 64'd0); chk("sat_3_tc", 64'(tc), 64'd1);
        tick(); chk("sat_4", 64'(data_out), 64'd0); chk("sat_4_tc", 64'(tc), 64'd1);
        chk("sat_unf", 64'(unf), 64'd1);
        idle(); clr_flags = 1;
        tick(); chk("clr_unf", 64'(unf), 64'd0); chk("clr_ovf", 64'(ovf), 64'd0);

        // Clear and new event in the same cycle: the event wins.
        idle(); en = 1; mode = 0; sat = 1; clr_flags = 1;
        tick(); chk("clr_race_unf", 64'(unf), 64'd1);

        // Load above limit clamps and flags overflow without tc.
        idle(); clr_flags = 1; tick();
        idle(); load = 1; data = 32'd200; limit = 32'd100;
        tick(); chk("ld_over", 64'(data_out), 64'd100);
        chk("ld_over_ovf", 64'(ovf), 64'd1); chk("ld_over_tc", 64'(tc), 64'd0);

        // Limit lowered below the count.
        idle(); clr_flags = 1; tick();
        idle(); load = 1; data = 32'd50; tick();
        idle(); en = 1; mode = 0; limit = 32'd20;
        tick(); chk("lim_low", 64'(data_out), 64'd20);
        chk("lim_low_ovf", 64'(ovf), 64'd1); chk("lim_low_tc", 64'(tc), 64'd1);

        // Limit zero pins the counter.
        idle(); en = 1; mode = 1; sat = 0; limit = 32'd0;
        tick(); tick(); chk("lim0", 64'(data_out), 64'd0); chk("lim0_tc", 64'(tc), 64'd1);
        mode = 0; tick(); chk("lim0_dn_unf", 64'(unf), 64'd1);

        // Full-width wrap.
        idle(); load = 1; data = 32'hFFFF_FFFE; limit = 32'hFFFF_FFFF;
        tick();
        idle(); en = 1; mode = 1; sat = 0;
        tick(); chk("fw_1", 64'(data_out), 64'hFFFF_FFFF);
        tick(); chk("fw_2", 64'(data_out), 64'd0); chk("fw_2_tc", 64'(tc), 64'd1);
        load = 1; en = 1; data = 32'd5;
        tick(); chk("ld_wins", 64'(data_out), 64'd5);

        // Reset on a boundary step suppresses tc.
        idle(); load = 1; data = 32'hFFFF_FFFF; tick();
        idle(); en = 1; mode = 1; rst = 0;
        tick(); chk("rst_tc_sup", 64'(tc), 64'd0); chk("rst_mid", 64'(data_out), 64'd0);
        rst = 1;

        // Randomized traffic.
        lim_r = 5;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: lim_r = 0;
                    1: lim_r = 1;
                    2: lim_r = $urandom_range(2, 12);
                    3: lim_r = 255;
                    4: lim_r = longint'($urandom);
                    default: lim_r = MAXV;
                endcase
            end
            limit     = W'(lim_r);
            rst       = ($urandom_range(0, 49) != 0);
            load      = ($urandom_range(0, 7) == 0);
            en        = ($urandom_range(0, 3) != 0);
            mode      = $urandom_range(0, 1) != 0;
            sat       = $urandom_range(0, 1) != 0;
            clr_flags = ($urandom_range(0, 9) == 0);
            if (lim_r < 64) data = W'($urandom_range(0, 32'(lim_r) + 3));
            else            data = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
